// File: rtl/game_pkg.sv
// Shared playfield constants and types used by the lane movers (cars and logs).
package game_pkg;
    localparam int GRID_W_DEF = 20;
    localparam int X_W_DEF    = 5;
    localparam bit DIR_LEFT   = 1'b0;
    localparam bit DIR_RIGHT  = 1'b1;

    typedef logic [3:0] level_t;

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } lane_state_t;
endpackage

// File: rtl/lane_traffic_if.sv
// Control and observation bundle for one traffic lane; the game core drives it
// as master, the lane mover answers as slave.
interface lane_traffic_if
    import game_pkg::*;
#(
    parameter int X_W      = X_W_DEF,
    parameter int NUM_CARS = 3
);
    logic                    i_Tick;
    level_t                  i_Level;
    logic                    i_Run;
    logic                    i_Restart;
    logic [X_W-1:0]          i_Frog_X;
    logic                    i_Frog_On_Lane;
    logic [NUM_CARS*X_W-1:0] o_Car_X;
    logic                    o_Step;
    logic                    o_Hit;

    modport master (
        output i_Tick, i_Level, i_Run, i_Restart, i_Frog_X, i_Frog_On_Lane,
        input  o_Car_X, o_Step, o_Hit
    );

    modport slave (
        input  i_Tick, i_Level, i_Run, i_Restart, i_Frog_X, i_Frog_On_Lane,
        output o_Car_X, o_Step, o_Hit
    );
endinterface

// File: rtl/lane_period_calc.sv
// Ticks-per-step for a given level: shrinks linearly with level and saturates
// at MIN_PERIOD. Shared by car and log lanes.
module lane_period_calc
    import game_pkg::*;
#(
    parameter logic [7:0] BASE_PERIOD = 8'd40,
    parameter logic [7:0] LEVEL_STEP  = 8'd3,
    parameter logic [7:0] MIN_PERIOD  = 8'd4
) (
    input  level_t     i_Level,
    output logic [7:0] o_Period
);
    logic [3:0]  lvl_s;
    logic [11:0] dec_s;

    // Level 0 counts as level 1; 12-bit product cannot overflow (14*255).
    always_comb begin
        lvl_s = (i_Level == 4'd0) ? 4'd1 : i_Level;
        dec_s = 12'(lvl_s - 4'd1) * 12'(LEVEL_STEP);
        if ({4'd0, BASE_PERIOD} >= (dec_s + {4'd0, MIN_PERIOD})) begin
            o_Period = BASE_PERIOD - dec_s[7:0];
        end else begin
            o_Period = MIN_PERIOD;
        end
    end
endmodule

// File: rtl/lane_traffic.sv
// One Frogger traffic lane: NUM_CARS cars stepping together with edge wrap,
// level-scaled step period, pause/restart control and a registered frog-hit flag.
module lane_traffic
    import game_pkg::*;
#(
    parameter int         GRID_W      = GRID_W_DEF,
    parameter int         X_W         = X_W_DEF,
    parameter int         NUM_CARS    = 3,
    parameter int         CAR_START   = 0,
    parameter int         CAR_SPACING = 7,
    parameter bit         DIRECTION   = DIR_RIGHT,
    parameter logic [7:0] BASE_PERIOD = 8'd40,
    parameter logic [7:0] LEVEL_STEP  = 8'd3,
    parameter logic [7:0] MIN_PERIOD  = 8'd4
) (
    input  logic          i_Clk,
    input  logic          i_Reset,
    lane_traffic_if.slave lane
);
    localparam int             CARS_W = NUM_CARS * X_W;
    localparam logic [X_W-1:0] X_MAX  = X_W'(GRID_W - 1);

    if (GRID_W > (1 << X_W)) begin : g_chk_grid
        $error("lane_traffic: GRID_W does not fit in X_W bits");
    end
    if (MIN_PERIOD == 8'd0) begin : g_chk_min
        $error("lane_traffic: MIN_PERIOD must be at least 1");
    end
    if ((NUM_CARS < 1) || (NUM_CARS > 8)) begin : g_chk_cars
        $error("lane_traffic: NUM_CARS must be 1..8");
    end

    function automatic logic [X_W-1:0] start_x(input int k);
        return X_W'((CAR_START + k * CAR_SPACING) % GRID_W);
    endfunction

    function automatic logic [CARS_W-1:0] start_vec();
        logic [CARS_W-1:0] v;
        for (int k = 0; k < NUM_CARS; k++) begin
            v[k*X_W +: X_W] = start_x(k);
        end
        return v;
    endfunction

    function automatic logic [X_W-1:0] step_x(input logic [X_W-1:0] x);
        if (DIRECTION == DIR_LEFT) begin
            return (x == '0) ? X_MAX : x - X_W'(1);
        end else begin
            return (x == X_MAX) ? '0 : x + X_W'(1);
        end
    endfunction

    localparam logic [CARS_W-1:0] START_POS = start_vec();

    lane_state_t       state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [CARS_W-1:0] car_q, car_d;
    logic              step_q, step_d;
    logic              hit_q, hit_d;
    logic [7:0]        period_s;
    logic              load_s, count_s, hit_s;

    lane_period_calc #(
        .BASE_PERIOD (BASE_PERIOD),
        .LEVEL_STEP  (LEVEL_STEP),
        .MIN_PERIOD  (MIN_PERIOD)
    ) u_period (
        .i_Level  (lane.i_Level),
        .o_Period (period_s)
    );

    // State register.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state_q <= INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: restart always re-enters INIT, otherwise i_Run selects RUN/PAUSED.
    always_comb begin
        state_d = state_q;
        if (lane.i_Restart) begin
            state_d = INIT;
        end else begin
            case (state_q)
                INIT:    state_d = lane.i_Run ? RUN : PAUSED;
                RUN:     state_d = lane.i_Run ? RUN : PAUSED;
                PAUSED:  state_d = lane.i_Run ? RUN : PAUSED;
                default: state_d = INIT;
            endcase
        end
    end

    // State-decoded controls.
    always_comb begin
        load_s  = lane.i_Restart || (state_q == INIT);
        count_s = (state_q == RUN) && lane.i_Tick && !lane.i_Restart;
    end

    // Counter and car datapath; a counter beyond a freshly shortened period steps at once.
    always_comb begin
        cnt_d  = cnt_q;
        car_d  = car_q;
        step_d = 1'b0;
        if (load_s) begin
            cnt_d = 8'd0;
            car_d = START_POS;
        end else if (count_s) begin
            if (cnt_q >= (period_s - 8'd1)) begin
                cnt_d  = 8'd0;
                step_d = 1'b1;
                for (int k = 0; k < NUM_CARS; k++) begin
                    car_d[k*X_W +: X_W] = step_x(car_q[k*X_W +: X_W]);
                end
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Frog overlap against the positions currently on the lane.
    always_comb begin
        hit_s = 1'b0;
        for (int k = 0; k < NUM_CARS; k++) begin
            if (car_q[k*X_W +: X_W] == lane.i_Frog_X) begin
                hit_s = 1'b1;
            end else begin
                hit_s = hit_s;
            end
        end
        hit_d = lane.i_Restart ? 1'b0 : (lane.i_Frog_On_Lane & hit_s);
    end

    // Datapath registers.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            cnt_q  <= 8'd0;
            car_q  <= START_POS;
            step_q <= 1'b0;
            hit_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            car_q  <= car_d;
            step_q <= step_d;
            hit_q  <= hit_d;
        end
    end

    assign lane.o_Car_X = car_q;
    assign lane.o_Step  = step_q;
    assign lane.o_Hit   = hit_q;
endmodule

// File: tb/tb_lane_traffic.sv
// Self-checking bench for lane_traffic: a right-moving and a left-moving lane
// driven in lockstep, checked against a cycle model and a step scoreboard.
module tb_lane_traffic;
    localparam int S_INIT = 0, S_RUN = 1, S_PAUSED = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lane_traffic_if #(.X_W(5), .NUM_CARS(3)) ifr ();
    lane_traffic_if #(.X_W(5), .NUM_CARS(3)) ifl ();

    assign ifl.i_Tick         = ifr.i_Tick;
    assign ifl.i_Level        = ifr.i_Level;
    assign ifl.i_Run          = ifr.i_Run;
    assign ifl.i_Restart      = ifr.i_Restart;
    assign ifl.i_Frog_X       = ifr.i_Frog_X;
    assign ifl.i_Frog_On_Lane = ifr.i_Frog_On_Lane;

    lane_traffic #(.DIRECTION(1'b1)) dut_r (.i_Clk(clk), .i_Reset(rst), .lane(ifr.slave));
    lane_traffic #(.DIRECTION(1'b0)) dut_l (.i_Clk(clk), .i_Reset(rst), .lane(ifl.slave));

    int n_tests = 0;
    int n_fail  = 0;

    logic       b_run;
    logic [3:0] b_level;
    logic [4:0] b_fx;
    logic       b_fon;

    int m_state, m_cnt;
    int m_car[3];
    int m_carl[3];
    logic [14:0] q_r[$];
    logic [14:0] q_l[$];
    logic last_step;

    typedef struct {
        logic [3:0] level;
        int         period;
    } per_vec_t;
    per_vec_t vecs[8];

    function automatic logic [14:0] pack3(input int c0, input int c1, input int c2);
        logic [4:0] a, b, c;
        a = 5'(c0);
        b = 5'(c1);
        c = 5'(c2);
        return {c, b, a};
    endfunction

    function automatic int exp_period(input int lvl_in);
        int lvl, p;
        lvl = (lvl_in == 0) ? 1 : lvl_in;
        p = 40 - (lvl - 1) * 3;
        if (p < 4) p = 4;
        return p;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_load();
        for (int k = 0; k < 3; k++) begin
            m_car[k]  = (k * 7) % 20;
            m_carl[k] = (k * 7) % 20;
        end
        m_cnt = 0;
    endtask

    task automatic cycle(input bit tick, input bit rs);
        int p;
        bit eh, es;
        @(negedge clk);
        ifr.i_Tick = tick;
        ifr.i_Restart = rs;
        ifr.i_Run = b_run;
        ifr.i_Level = b_level;
        ifr.i_Frog_X = b_fx;
        ifr.i_Frog_On_Lane = b_fon;
        p  = exp_period(int'(b_level));
        eh = 1'b0;
        for (int k = 0; k < 3; k++) if (b_fon && m_car[k] == int'(b_fx)) eh = 1'b1;
        es = 1'b0;
        if (rs) begin
            model_load();
            eh = 1'b0;
        end else if (m_state == S_INIT) begin
            model_load();
        end else if (m_state == S_RUN && tick) begin
            if (m_cnt >= p - 1) begin
                es = 1'b1;
                m_cnt = 0;
                for (int k = 0; k < 3; k++) begin
                    m_car[k]  = (m_car[k] == 19) ? 0 : m_car[k] + 1;
                    m_carl[k] = (m_carl[k] == 0) ? 19 : m_carl[k] - 1;
                end
                q_r.push_back(pack3(m_car[0], m_car[1], m_car[2]));
                q_l.push_back(pack3(m_carl[0], m_carl[1], m_carl[2]));
            end else begin
                m_cnt++;
            end
        end
        m_state = rs ? S_INIT : (b_run ? S_RUN : S_PAUSED);
        @(posedge clk);
        #1;
        check("step_r", ifr.o_Step, es);
        check("step_l", ifl.o_Step, es);
        check("hit", ifr.o_Hit, eh);
        if (ifr.o_Step) begin
            if (q_r.size() == 0) check("sb_r_unexpected", 32'd1, 32'd0);
            else check("car_r", ifr.o_Car_X, q_r.pop_front());
        end
        if (ifl.o_Step) begin
            if (q_l.size() == 0) check("sb_l_unexpected", 32'd1, 32'd0);
            else check("car_l", ifl.o_Car_X, q_l.pop_front());
        end
        last_step = ifr.o_Step;
    endtask

    task automatic run_to_step(output int n, input int bound);
        n = 0;
        last_step = 1'b0;
        while (!last_step && n < bound) begin
            cycle(1'b1, 1'b0);
            n++;
        end
        if (!last_step) check("step_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int n;
        vecs[0] = '{4'd1, 40};
        vecs[1] = '{4'd0, 40};
        vecs[2] = '{4'd2, 37};
        vecs[3] = '{4'd5, 28};
        vecs[4] = '{4'd12, 7};
        vecs[5] = '{4'd13, 4};
        vecs[6] = '{4'd14, 4};
        vecs[7] = '{4'd15, 4};

        b_run = 1'b1; b_level = 4'd1; b_fx = 5'd0; b_fon = 1'b0;
        ifr.i_Tick = 1'b0; ifr.i_Restart = 1'b0; ifr.i_Run = 1'b1;
        ifr.i_Level = 4'd1; ifr.i_Frog_X = 5'd0; ifr.i_Frog_On_Lane = 1'b0;
        rst = 1'b1;
        m_state = S_INIT;
        model_load();
        #12;
        check("rst_car", ifr.o_Car_X, pack3(0, 7, 14));
        check("rst_step", ifr.o_Step, 32'd0);
        check("rst_hit", ifr.o_Hit, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // first step at level 1 after exactly 40 ticks
        cycle(1'b0, 1'b0);
        run_to_step(n, 100);
        check("lvl1_period", n, 32'd40);
        check("first_step_pos", ifr.o_Car_X, pack3(1, 8, 15));

        // period table: sync on a step at the new level, then measure
        for (int i = 0; i < 8; i++) begin
            b_level = vecs[i].level;
            run_to_step(n, 300);
            run_to_step(n, 300);
            check("period_tbl", n, vecs[i].period);
        end

        // level change mid-count past the new period steps on the next tick
        b_level = 4'd1;
        run_to_step(n, 300);
        repeat (10) cycle(1'b1, 1'b0);
        b_level = 4'd15;
        cycle(1'b1, 1'b0);
        check("lvl_change_step", ifr.o_Step, 32'd1);

        // wrap: from start, 19 steps puts car 0 at 19, the 20th wraps to 0
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);
        run_to_step(n, 50);
        check("left_wrap", ifl.o_Car_X, pack3(19, 6, 13));
        for (int s = 1; s < 19; s++) run_to_step(n, 50);
        check("right_at_19", ifr.o_Car_X, pack3(19, 6, 13));
        run_to_step(n, 50);
        check("right_wrap", ifr.o_Car_X, pack3(0, 7, 14));

        // pause holds positions and count
        b_level = 4'd0;
        run_to_step(n, 300);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        b_run = 1'b0;
        cycle(1'b0, 1'b0);
        repeat (100) cycle(1'b1, 1'b0);
        check("pause_pos", ifr.o_Car_X, pack3(m_car[0], m_car[1], m_car[2]));
        b_run = 1'b1;
        cycle(1'b0, 1'b0);
        run_to_step(n, 300);
        check("pause_cnt_held", n, 32'd38);

        // frog hit while paused at start positions
        b_run = 1'b0;
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);
        b_fon = 1'b1; b_fx = 5'd7;
        cycle(1'b0, 1'b0);
        check("hit_car1", ifr.o_Hit, 32'd1);
        b_fon = 1'b0;
        cycle(1'b0, 1'b0);
        check("hit_off_lane", ifr.o_Hit, 32'd0);
        b_fon = 1'b1; b_fx = 5'd8;
        cycle(1'b0, 1'b0);
        check("hit_miss", ifr.o_Hit, 32'd0);
        b_fx = 5'd14;
        cycle(1'b0, 1'b0);
        check("hit_car2", ifr.o_Hit, 32'd1);

        // restart on the completing tick wins over the step
        b_run = 1'b1; b_level = 4'd15;
        cycle(1'b0, 1'b0);
        run_to_step(n, 50);
        repeat (3) cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b1);
        check("rs_no_step", ifr.o_Step, 32'd0);
        check("rs_pos", ifr.o_Car_X, pack3(0, 7, 14));
        check("rs_hit_clr", ifr.o_Hit, 32'd0);
        cycle(1'b0, 1'b0);
        run_to_step(n, 50);
        check("rs_cnt_zero", n, 32'd4);

        // asynchronous reset mid-count, with hit set beforehand
        b_fx = 5'(m_car[0]);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        check("pre_rst_hit", ifr.o_Hit, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_car", ifr.o_Car_X, pack3(0, 7, 14));
        check("arst_step", ifr.o_Step, 32'd0);
        check("arst_hit", ifr.o_Hit, 32'd0);
        check("arst_car_l", ifl.o_Car_X, pack3(0, 7, 14));
        @(negedge clk);
        rst = 1'b0;
        m_state = S_INIT;
        model_load();
        q_r.delete();
        q_l.delete();
        b_fon = 1'b0;
        cycle(1'b0, 1'b0);
        run_to_step(n, 50);
        check("post_rst_period", n, 32'd4);

        check("sb_r_drained", q_r.size(), 32'd0);
        check("sb_l_drained", q_l.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
